// File: rtl/eprisc_rom_arbiter.sv
// rtl/eprisc_rom_arbiter.sv - two-port ROM read arbiter with a fixed 2-cycle grant-to-valid pipeline
// Define EPRISC_ROM_ARB_RR_EN for round-robin arbitration; fixed priority to port 0 otherwise.
module eprisc_rom_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReq0,
  input  logic              iReq1,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [ADDR_W-1:0] iAddr1,
  output logic              oGnt0,
  output logic              oGnt1,
  output logic              oValid0,
  output logic              oValid1,
  output logic [DATA_W-1:0] oData0,
  output logic [DATA_W-1:0] oData1,
  output logic [ADDR_W-1:0] oRomAddr,
  output logic              oRomEnable,
  input  logic [DATA_W-1:0] iRomData
);

  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              fl_vld_q, fl_vld_d;
  logic              fl_port_q, fl_port_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_port_q, rsp_port_d;
  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              prefer0;
  logic              gnt0, gnt1;

`ifdef EPRISC_ROM_ARB_RR_EN
  logic ptr_q, ptr_d;

  assign prefer0 = (ptr_q == 1'b0);

  always_comb begin
    ptr_d = ptr_q;
    if (gnt0)      ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;
  end

  always_ff @(posedge iClk) begin
    if (iRst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end
`else
  assign prefer0 = 1'b1;
`endif

  always_comb begin
    gnt0 = !iRst && iReq0 && (!iReq1 || prefer0);
    gnt1 = !iRst && iReq1 && !gnt0;
  end

  always_comb begin
    last_addr_d = last_addr_q;
    fl_vld_d    = gnt0 || gnt1;
    fl_port_d   = gnt1;
    rsp_vld_d   = fl_vld_q;
    rsp_port_d  = fl_port_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    if (gnt0)      last_addr_d = iAddr0;
    else if (gnt1) last_addr_d = iAddr1;
    // ROM data is valid only in the cycle after the address cycle.
    if (fl_vld_q) begin
      if (fl_port_q) data1_d = iRomData;
      else           data0_d = iRomData;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      last_addr_q <= '0;
      fl_vld_q    <= 1'b0;
      fl_port_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_port_q  <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      fl_vld_q    <= fl_vld_d;
      fl_port_q   <= fl_port_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_port_q  <= rsp_port_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
    end
  end

  // Outputs are masked while reset is high so in-flight state never leaks out.
  always_comb begin
    oGnt0      = gnt0;
    oGnt1      = gnt1;
    oRomAddr   = iRst ? '0 : last_addr_d;
    oRomEnable = fl_vld_q && !iRst;
    oValid0    = rsp_vld_q && !rsp_port_q && !iRst;
    oValid1    = rsp_vld_q && rsp_port_q && !iRst;
    oData0     = iRst ? '0 : data0_q;
    oData1     = iRst ? '0 : data1_q;
  end

endmodule

// File: doc/eprisc_rom_arbiter.md
EPRISC_ROM_ARBITER -- requirements
Module: eprisc_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the ROM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the ROM word width.
REQ-003 SHALL have port iClk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port iRst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports iReq0/iReq1  input  1  read request from port 0 (fetch) and port 1 (bus/debug).
REQ-006 SHALL have ports iAddr0/iAddr1  input  ADDR_W  word address for each requesting port.
REQ-007 SHALL have ports oGnt0/oGnt1  output  1  combinational same-cycle acceptance of a request.
REQ-008 SHALL have ports oValid0/oValid1  output  1  registered one-cycle response strobes.
REQ-009 SHALL have ports oData0/oData1  output  DATA_W  registered response data, held until the port's next response.
REQ-010 SHALL have port oRomAddr  output  ADDR_W  address to the ROM.
REQ-011 SHALL have port oRomEnable  output  1  ROM output-enable.
REQ-012 SHALL have port iRomData  input  DATA_W  ROM read data (high-Z when oRomEnable is low).

Function
REQ-013 SHALL model the ROM as registering its data on the iClk edge that ends the address cycle; data is valid in the following cycle while oRomEnable is high.
REQ-014 SHALL accept at most one request per cycle and SHALL assert oGnt of the winning port only.
REQ-015 SHALL drive oRomAddr combinationally from the granted port's address in grant cycle N; when there is no grant, oRomAddr SHALL be the last granted address.
REQ-016 SHALL register the tag {in-flight, port} at the end of cycle N and assert oRomEnable in cycle N+1 only.
REQ-017 SHALL capture iRomData into oDataX at the end of cycle N+1 and pulse oValidX for exactly cycle N+2; fixed latency is 2 cycles from grant to valid.
REQ-018 SHALL sustain back-to-back grants on consecutive cycles; a new grant SHALL be accepted while earlier reads are in flight, and responses SHALL return in grant order.
REQ-019 SHALL require the requester to hold iReqX and iAddrX stable until oGntX; an address change before the grant SHALL be used as-is, with no error.
REQ-020 SHALL grant the sole requester when only one port requests.
REQ-021 SHALL resolve simultaneous requests per REQ-030/REQ-031.
REQ-022 SHALL never assert oValid0 and oValid1 in the same cycle.
REQ-023 SHALL leave oDataX unchanged on cycles with oValidX low.

Reset
REQ-024 SHALL, while iRst is high, force oGnt0=oGnt1=0, oValid0=oValid1=0, oRomEnable=0, oRomAddr=0, oData0=oData1=0, and the round-robin pointer to port 0.
REQ-025 SHALL discard all in-flight reads when iRst is asserted mid-operation; no oValid SHALL be produced for them.
REQ-026 SHALL accept requests again in the first cycle after iRst deasserts.

Configuration
REQ-027 SHALL compile round-robin arbitration only when macro EPRISC_ROM_ARB_RR_EN is defined.
REQ-028 SHALL apply fixed priority to port 0 on simultaneous requests when EPRISC_ROM_ARB_RR_EN is undefined; port 1 is served only when iReq0 is low.
REQ-029 SHALL maintain a 1-bit pointer when EPRISC_ROM_ARB_RR_EN is defined.
REQ-030 SHALL, with EPRISC_ROM_ARB_RR_EN defined, grant the port named by the pointer on simultaneous requests.
REQ-031 SHALL, with EPRISC_ROM_ARB_RR_EN defined, set the pointer to the other port after any grant; the pointer is unchanged on cycles without a grant.

Verification
REQ-032 SHALL cover single read: ROM model 0x00=0x24413345; iReq0=1, iAddr0=0x00 in cycle 1 -> oGnt0 high in cycle 1, oRomEnable high in cycle 2, oValid0 high in cycle 3 with oData0=0x24413345.
REQ-033 SHALL cover back-to-back reads: port 0 reads 0x01 (0x25000000) then 0x02 (0x26000200) on consecutive cycles -> oValid0 in cycles 3 and 4 with the data in order.
REQ-034 SHALL cover contention with RR_EN defined: both ports hold requests (0x03, 0x04) from reset release -> grants alternate 0,1,0,1 and oValid alternates, never both high.
REQ-035 SHALL cover contention with RR_EN undefined: both ports hold requests -> port 0 is granted every cycle and port 1 only after iReq0 drops.
REQ-036 SHALL cover reset mid-flight: grant at cycle 1, iRst high in cycle 2 -> no oValid in cycles 2-4; all outputs at reset values.
REQ-037 SHALL cover idle cycles: no requests for 5 cycles -> oRomEnable low, oRomAddr holds the last granted value, oData0/oData1 unchanged.
